// File: rtl/fetch_buf.sv
// Instruction fetch buffer: queues {pc, insn} pairs from IRAM and hands the
// oldest to decode over valid/ready, with flush, kill and stall handling.
module fetch_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_valid,
  input  logic [63:0] i_pc,
  input  logic [31:0] i_insn,
  output logic        o_stall,
  output logic        o_valid,
  output logic [63:0] o_pc,
  output logic [31:0] o_insn,
  input  logic        i_ready,
  output logic        o_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          kill;
  logic          ovf;
  logic [61:0]   pc_mem   [DEPTH];
  logic [31:0]   insn_mem [DEPTH];

  logic full;
  logic pop;
  logic push;
  logic ovf_set;

  // Handshake qualifiers; a word arriving right after a redirect is stale.
  always_comb begin
    full    = (count == CW'(DEPTH));
    pop     = o_valid & i_ready;
    push    = i_valid & ~kill & ~i_flush & (~full | pop);
    ovf_set = i_valid & ~kill & ~i_flush & full & ~pop;
  end

  assign o_valid = (count != '0);
  assign o_pc    = {pc_mem[rd_ptr], 2'b00};
  assign o_insn  = insn_mem[rd_ptr];
  // Threshold leaves one slot for the word already in flight from fetch.
  assign o_stall = (count >= CW'(DEPTH - 1)) & ~i_flush;
  assign o_ovf   = ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      kill   <= 1'b0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        insn_mem[i] <= '0;
      end
    end else begin
      kill <= i_flush;
      if (ovf_set) begin
        ovf <= 1'b1;
      end
      if (push) begin
        pc_mem[wr_ptr]   <= i_pc[63:2];
        insn_mem[wr_ptr] <= i_insn;
      end
      if (i_flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: doc/fetch_buf.md
# fetch_buf

Instruction fetch buffer between the fetch unit and decode. It captures each fetched instruction word from IRAM together with its fetch PC, queues the pair in a small FIFO, and presents the oldest entry to decode through a valid/ready handshake. It also tells the fetch unit to stall when the queue is close to full, and discards everything still queued or in flight on a pipeline flush.

## Interface
- DEPTH, 4, number of FIFO entries; power of two, ≥2.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset; asserted when 0.
- i_flush  input  1  pipeline redirect; same-cycle pulse also seen by the fetch unit.
- i_valid  input  1  an IRAM read returns this cycle.
- i_pc  input  64  fetch PC of the returning word, with bits [1:0] = 0.
- i_insn  input  32  IRAM read data.
- o_stall  output  1  fetch unit must hold its PC.
- o_valid  output  1  head entry valid toward decode.
- o_pc  output  64  head entry PC.
- o_insn  output  32  head entry instruction.
- i_ready  input  1  decode accepts the head entry this cycle.
- o_ovf  output  1  sticky overflow error: a push was dropped.

## Operation
- Storage: DEPTH entries of {pc[63:2], insn[31:0]}. PC bits [1:0] are not stored; o_pc[1:0] is always 0.
- Pointers: read pointer and write pointer are each log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits, range 0..DEPTH.
- Pop:
  - pop = o_valid & i_ready.
  - o_valid = (count != 0).
  - o_pc and o_insn are the head entry, driven straight from the storage array (register read, no extra logic stage).
  - When o_valid = 0, o_pc and o_insn hold the stale entry; decode ignores them.
- Push:
  - push = i_valid & ~kill & ~i_flush & (count < DEPTH | pop).
  - A push at full is accepted only when a pop happens in the same cycle.
- Kill: a 1-bit register set by i_flush and cleared on the next cycle.
  - While kill = 1, i_valid is ignored.
  - Reason: the IRAM word returning in the cycle after a redirect was addressed on the old path.
- Flush, which has priority over everything else:
  - count, both pointers and the head are reset, so o_valid = 0 from the next cycle.
  - Any same-cycle push is dropped.
  - Any same-cycle pop still completes as seen by decode; the FIFO is empty afterwards regardless.
- Stall: o_stall = (count ≥ DEPTH-1) & ~i_flush.
  - The DEPTH-1 threshold absorbs the one word already in flight from the fetch unit's registered read.
  - This leaves one free slot for that word.
- Overflow: if i_valid & ~kill & ~i_flush & (count == DEPTH) & ~pop, the word is dropped and o_ovf is set.
  - o_ovf stays set until reset. This is a verification and debug hook; it never occurs when fetch honours o_stall.
- Count update: count_next = count + push - pop, or 0 on flush.

## Timing
- Reset (rst = 0, asynchronous): count = 0, both pointers = 0, kill = 0, o_ovf = 0, o_valid = 0, o_stall = 0.
  - o_pc and o_insn reset to 0, since the storage array resets too.
  - Release is synchronous to clk. The first push can happen in the first cycle after release.
- Latency: a word pushed in cycle N is visible at o_valid/o_pc/o_insn in cycle N+1, not combinationally. No bypass path.
- Throughput: one push plus one pop per cycle, sustained, at any occupancy.
- o_stall is combinational from count and i_flush. It reflects the occupancy after the previous edge.
- Flush in cycle N:
  - o_valid = 0 in cycle N+1.
  - i_valid in N+1 is discarded.
  - The first accepted word arrives no earlier than N+2.
- Back-to-back flushes in N and N+1: kill is re-armed, so i_valid in both N+1 and N+2 is discarded.
- Reset asserted mid-operation clears all state immediately, including a pending kill and o_ovf.

## Test plan
- Streaming: push PCs 0x1000, 0x1004, 0x1008, … with i_ready = 1 every cycle → each word appears one cycle later in order; count stays ≤1; o_stall = 0.
- Fill/stall, DEPTH = 4, i_ready = 0: push 3 words → o_stall = 1 once count = 3; push the 4th → count = 4, o_ovf = 0. Push a 5th → dropped, o_ovf = 1 and stays 1.
- Full with simultaneous push and pop: at count = 4, assert i_valid and i_ready together → count stays 4, the new word enters at the tail, the old head leaves, order is preserved.
- Flush: with 3 entries queued, assert i_flush together with i_valid (PC 0x2000) → o_valid = 0 next cycle. i_valid with PC 0x2004 in the following cycle is discarded. PC 0x3000 presented one cycle later is the first entry out.
- Wrap-around: run 10 pushes and 10 pops with random i_ready gaps → the output PC sequence exactly matches the input sequence across pointer wraps.
- Asynchronous reset mid-burst: drop rst with count = 2 and o_ovf = 1, between clock edges → o_valid, o_stall and o_ovf go to 0 immediately; after release, the first pushed word emerges normally.
